exu_div_param_ctl: RTL and testbench

EXU_DIV_PARAM_CTL -- requirements
Module: exu_div_param_ctl

---
 rtl/exu_div_param_ctl.sv | 215 +++++++++++++++++++++
 tb/tb_exu_div_param_ctl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_div_param_ctl.sv
// exu_div_param_ctl: iterative restoring radix-2 integer divider for the EXU.
// Signed/unsigned quotient or remainder, XLEN = 32 or 64.
// Divide-by-zero and signed overflow return a result one cycle after acceptance.
// Optional macro RV_DIV_SMALLNUM_EN adds the same short path when both
// absolute operands are below 16. fast_div_disable turns that path off at run time.
module exu_div_param_ctl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            scan_mode,
  input  logic            flush_lower,
  input  logic            fast_div_disable,
  input  logic            dp_valid,
  input  logic            dp_sign,
  input  logic            dp_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_stall,
  output logic            finish,
  output logic            finish_early,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  // Two's complement negation
  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, r_q, r_d, out_q, out_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, rem_q, rem_d, sign_q, sign_d;
  logic            finish_q, finish_d, early_q, early_d, stall_q, stall_d;

  logic            dvd_neg_s, dvs_neg_s, q_neg_s, div_zero_s, ovf_s;
  logic            small_s, short_s, q_bit_s, unused_s;
  logic [XLEN-1:0] dvd_abs_s, dvs_abs_s, short_res_s, small_res_s;
  logic [XLEN-1:0] r_nxt_s, a_nxt_s, fix_res_s;
  logic [XLEN:0]   r_sh_s;
  logic [XLEN+1:0] diff_s;

  // Operand sign analysis and special-case detection at request time
  assign dvd_neg_s  = dp_sign & dividend[XLEN-1];
  assign dvs_neg_s  = dp_sign & divisor[XLEN-1];
  assign q_neg_s    = dvd_neg_s ^ dvs_neg_s;
  assign dvd_abs_s  = dvd_neg_s ? neg_f(dividend) : dividend;
  assign dvs_abs_s  = dvs_neg_s ? neg_f(divisor) : divisor;
  assign div_zero_s = (divisor == {XLEN{1'b0}});
  assign ovf_s      = dp_sign & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == {XLEN{1'b1}});

`ifdef RV_DIV_SMALLNUM_EN
  // 4-bit restoring divide; returns {quotient, remainder}
  function automatic logic [7:0] small_div_f(input logic [3:0] n, input logic [3:0] d);
    logic [4:0] r;
    logic [3:0] q;
    r = 5'd0;
    q = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      r = {r[3:0], n[i]};
      if (r >= {1'b0, d}) begin
        r    = r - {1'b0, d};
        q[i] = 1'b1;
      end
    end
    return {q, r[3:0]};
  endfunction

  logic [7:0]      small_qr_s;
  logic [XLEN-1:0] small_q_s, small_r_s;
  assign small_s     = ~fast_div_disable & ~div_zero_s
                     & (dvd_abs_s[XLEN-1:4] == {(XLEN-4){1'b0}})
                     & (dvs_abs_s[XLEN-1:4] == {(XLEN-4){1'b0}});
  assign small_qr_s  = small_div_f(dvd_abs_s[3:0], dvs_abs_s[3:0]);
  assign small_q_s   = {{(XLEN-4){1'b0}}, small_qr_s[7:4]};
  assign small_r_s   = {{(XLEN-4){1'b0}}, small_qr_s[3:0]};
  assign small_res_s = dp_rem ? (dvd_neg_s ? neg_f(small_r_s) : small_r_s)
                              : (q_neg_s ? neg_f(small_q_s) : small_q_s);
  assign unused_s    = ^{scan_mode, diff_s[XLEN]};
`else
  assign small_s     = 1'b0;
  assign small_res_s = {XLEN{1'b0}};
  assign unused_s    = ^{scan_mode, fast_div_disable, diff_s[XLEN]};
`endif

  assign short_s     = div_zero_s | ovf_s | small_s;
  assign short_res_s = div_zero_s ? (dp_rem ? dividend : {XLEN{1'b1}})
                     : ovf_s      ? (dp_rem ? {XLEN{1'b0}} : dividend)
                     : small_res_s;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  assign r_sh_s  = {r_q, a_q[XLEN-1]};
  assign diff_s  = {1'b0, r_sh_s} - {2'b00, b_q};
  assign q_bit_s = ~diff_s[XLEN+1];
  assign r_nxt_s = q_bit_s ? diff_s[XLEN-1:0] : r_sh_s[XLEN-1:0];
  assign a_nxt_s = {a_q[XLEN-2:0], q_bit_s};

  // Sign fix-up of the final quotient/remainder and result selection
  assign fix_res_s = rem_q ? (r_neg_q ? neg_f(r_nxt_s) : r_nxt_s)
                           : ((q_neg_q & sign_q) ? neg_f(a_nxt_s) : a_nxt_s);

  // Next-state logic for the FSM, datapath and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    rem_d    = rem_q;
    sign_d   = sign_q;
    out_d    = out_q;
    finish_d = 1'b0;
    early_d  = 1'b0;
    stall_d  = stall_q;
    if (flush_lower) begin
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
      stall_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dp_valid) begin
            a_d     = dvd_abs_s;
            b_d     = dvs_abs_s;
            r_d     = {XLEN{1'b0}};
            q_neg_d = q_neg_s;
            r_neg_d = dvd_neg_s;
            rem_d   = dp_rem;
            sign_d  = dp_sign;
            cnt_d   = {CW{1'b0}};
            stall_d = 1'b1;
            if (short_s) begin
              state_d  = FIX;
              out_d    = short_res_s;
              finish_d = 1'b1;
              early_d  = 1'b1;
            end else begin
              state_d = ITER;
            end
          end else begin
            stall_d = 1'b0;
          end
        end
        ITER: begin
          a_d   = a_nxt_s;
          r_d   = r_nxt_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_CNT) begin
            state_d  = FIX;
            out_d    = fix_res_s;
            finish_d = 1'b1;
          end else begin
            state_d = ITER;
          end
        end
        FIX: begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
          stall_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
          stall_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      r_q      <= {XLEN{1'b0}};
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rem_q    <= 1'b0;
      sign_q   <= 1'b0;
      out_q    <= {XLEN{1'b0}};
      finish_q <= 1'b0;
      early_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      rem_q    <= rem_d;
      sign_q   <= sign_d;
      out_q    <= out_d;
      finish_q <= finish_d;
      early_q  <= early_d;
      stall_q  <= stall_d;
    end
  end

  assign div_stall    = stall_q;
  assign finish       = finish_q;
  assign finish_early = early_q;
  assign out          = out_q;

endmodule

// File: tb/tb_exu_div_param_ctl.sv
// Testbench for exu_div_param_ctl: one 64-bit and one 32-bit instance with shared
// control inputs. A timing/arithmetic model predicts finish, finish_early,
// div_stall and out every cycle. Directed vectors carry literal expectations.
module tb_exu_div_param_ctl;

  logic        clk;
  logic        rst_l;
  logic        scan_mode;
  logic        flush_lower;
  logic        fast_div_disable;
  logic        dp_valid;
  logic        dp_sign;
  logic        dp_rem;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        st64, fin64, early64;
  logic [63:0] out64;
  logic        st32, fin32, early32;
  logic [31:0] out32;

  int checks;
  int failures;

  // Observations recorded by the compare process
  int lat_obs[2];
  bit early_obs[2];
  int fin_cnt[2];

  exu_div_param_ctl #(.XLEN(64)) dut64 (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .flush_lower(flush_lower),
    .fast_div_disable(fast_div_disable), .dp_valid(dp_valid), .dp_sign(dp_sign),
    .dp_rem(dp_rem), .dividend(op_a), .divisor(op_b), .div_stall(st64),
    .finish(fin64), .finish_early(early64), .out(out64)
  );

  exu_div_param_ctl #(.XLEN(32)) dut32 (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .flush_lower(flush_lower),
    .fast_div_disable(fast_div_disable), .dp_valid(dp_valid), .dp_sign(dp_sign),
    .dp_rem(dp_rem), .dividend(op_a[31:0]), .divisor(op_b[31:0]), .div_stall(st32),
    .finish(fin32), .finish_early(early32), .out(out32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference divide: returns {short_path, result} for width w
  function automatic logic [64:0] model_div(input int w, input logic [63:0] a_in,
                                            input logic [63:0] b_in, input logic sgn,
                                            input logic rem, input logic fdd);
    logic [63:0] m, msb, a, b, q, r;
    longint sa, sb, sq, sr;
    logic sh;
    m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    msb = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    a = a_in & m;
    b = b_in & m;
    sa = (w == 64) ? $signed(a) : $signed({{32{a[31]}}, a[31:0]});
    sb = (w == 64) ? $signed(b) : $signed({{32{b[31]}}, b[31:0]});
    sh = 1'b0;
    if (b == 64'd0) begin
      sh = 1'b1; q = m; r = a;
    end else if (sgn && a == msb && b == m) begin
      sh = 1'b1; q = a; r = 64'd0;
    end else begin
      if (sgn) begin
        sq = sa / sb; sr = sa % sb; q = sq; r = sr;
      end else begin
        q = a / b; r = a % b;
      end
`ifdef RV_DIV_SMALLNUM_EN
      if (!fdd) begin
        if (sgn) sh = (sa > -16 && sa < 16 && sb > -16 && sb < 16);
        else     sh = (a < 64'd16 && b < 64'd16);
      end
`else
      if (fdd) sh = 1'b0;
`endif
    end
    return {sh, (rem ? r : q) & m};
  endfunction

  // Cycle-by-cycle compare against the model; sampled on the falling edge
  initial begin : compare
    bit busy[2];
    int fin_at[2];
    int acc_cyc[2];
    bit early_e[2];
    logic [63:0] res_e[2];
    logic [63:0] out_e[2];
    logic [64:0] mr;
    logic [63:0] ao;
    logic af, ae, as;
    bit exp_fin;
    int wd;
    int cyc;
    cyc = 0;
    for (int w = 0; w < 2; w++) begin
      busy[w] = 1'b0; fin_at[w] = 0; acc_cyc[w] = 0; early_e[w] = 1'b0;
      res_e[w] = 64'd0; out_e[w] = 64'd0; lat_obs[w] = 0; early_obs[w] = 1'b0; fin_cnt[w] = 0;
    end
    forever begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        wd = (w == 0) ? 64 : 32;
        ao = (w == 0) ? out64 : {32'd0, out32};
        af = (w == 0) ? fin64 : fin32;
        ae = (w == 0) ? early64 : early32;
        as = (w == 0) ? st64 : st32;
        if (!rst_l) begin
          busy[w] = 1'b0;
          out_e[w] = 64'd0;
          chk($sformatf("rst_finish_w%0d", wd), {63'd0, af}, 64'd0);
          chk($sformatf("rst_early_w%0d", wd), {63'd0, ae}, 64'd0);
          chk($sformatf("rst_stall_w%0d", wd), {63'd0, as}, 64'd0);
          chk($sformatf("rst_out_w%0d", wd), ao, 64'd0);
        end else begin
          exp_fin = busy[w] && (fin_at[w] == cyc);
          if (exp_fin) out_e[w] = res_e[w];
          chk($sformatf("finish_w%0d", wd), {63'd0, af}, {63'd0, exp_fin});
          chk($sformatf("finish_early_w%0d", wd), {63'd0, ae}, {63'd0, exp_fin & early_e[w]});
          chk($sformatf("div_stall_w%0d", wd), {63'd0, as}, {63'd0, busy[w]});
          chk($sformatf("out_w%0d", wd), ao, out_e[w]);
          if (af) begin
            fin_cnt[w]++;
            lat_obs[w] = cyc - acc_cyc[w];
            early_obs[w] = ae;
          end
          if (flush_lower) begin
            busy[w] = 1'b0;
          end else if (exp_fin) begin
            busy[w] = 1'b0;
          end else if (!busy[w] && dp_valid) begin
            mr = model_div(wd, op_a, op_b, dp_sign, dp_rem, fast_div_disable);
            busy[w] = 1'b1;
            acc_cyc[w] = cyc;
            early_e[w] = mr[64];
            res_e[w] = mr[63:0];
            fin_at[w] = cyc + (mr[64] ? 1 : wd + 1);
          end
        end
      end
      cyc++;
    end
  end

  task automatic go(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                    input logic rem, input logic fdd);
    @(posedge clk); #1;
    op_a = a; op_b = b; dp_sign = sgn; dp_rem = rem; fast_div_disable = fdd;
    dp_valid = 1'b1;
    @(posedge clk); #1;
    dp_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int i;
    i = 0;
    @(negedge clk);
    while ((st64 || st32) && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("idle_wait", {63'd0, st64 | st32}, 64'd0);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] M9   = 64'hFFFF_FFFF_FFFF_FFF7;

  // Directed stimulus with literal expectations
  initial begin : stim
    int fc0, fc1;
    logic [64:0] mr;
    checks = 0; failures = 0;
    rst_l = 1'b0; scan_mode = 1'b0; flush_lower = 1'b0; fast_div_disable = 1'b0;
    dp_valid = 1'b0; dp_sign = 1'b0; dp_rem = 1'b0; op_a = 64'd0; op_b = 64'd0;

    // Pin the model with hand-computed values
    mr = model_div(64, 64'h7d0, 64'd3, 1'b0, 1'b0, 1'b0); chk("model_7d0_q", mr[63:0], 64'h29a);
    mr = model_div(64, 64'h7d0, 64'd3, 1'b0, 1'b1, 1'b0); chk("model_7d0_r", mr[63:0], 64'h2);
    mr = model_div(32, M7, 64'd2, 1'b1, 1'b0, 1'b0);      chk("model_m7_q32", mr[63:0], 64'hFFFF_FFFD);
    mr = model_div(32, M7, 64'd2, 1'b1, 1'b1, 1'b0);      chk("model_m7_r32", mr[63:0], 64'hFFFF_FFFF);
    mr = model_div(64, 64'h8000_0000_0000_0000, ONES, 1'b1, 1'b0, 1'b0);
    chk("model_ovf_q", mr, {1'b1, 64'h8000_0000_0000_0000});
    mr = model_div(64, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0);   chk("model_dz_r", mr, {1'b1, 64'd5});

    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;

    go(64'h7d0, 64'd3, 1'b0, 1'b0, 1'b0); wait_idle();
    chk("q7d0_out64", out64, 64'h29a); chk("q7d0_out32", {32'd0, out32}, 64'h29a);
    chk("q7d0_lat64", lat_obs[0], 64'd65); chk("q7d0_lat32", lat_obs[1], 64'd33);
    chk("q7d0_early64", {63'd0, early_obs[0]}, 64'd0);
    go(64'h7d0, 64'd3, 1'b0, 1'b1, 1'b0); wait_idle();
    chk("r7d0_out64", out64, 64'h2);

    go(M7, 64'd2, 1'b1, 1'b0, 1'b0); wait_idle();
    chk("qm7_out32", {32'd0, out32}, 64'hFFFF_FFFD); chk("qm7_lat32", lat_obs[1], 64'd33);
    chk("qm7_out64", out64, 64'hFFFF_FFFF_FFFF_FFFD);
    go(M7, 64'd2, 1'b1, 1'b1, 1'b0); wait_idle();
    chk("rm7_out32", {32'd0, out32}, 64'hFFFF_FFFF);

    go(64'd5, 64'd0, 1'b0, 1'b0, 1'b0); wait_idle();
    chk("dz_q_out64", out64, ONES); chk("dz_q_out32", {32'd0, out32}, 64'hFFFF_FFFF);
    chk("dz_lat64", lat_obs[0], 64'd1); chk("dz_early64", {63'd0, early_obs[0]}, 64'd1);
    go(64'd5, 64'd0, 1'b0, 1'b1, 1'b0); wait_idle();
    chk("dz_r_out64", out64, 64'd5);
    go(64'd5, 64'd0, 1'b1, 1'b0, 1'b0); wait_idle();
    chk("dz_sq_out32", {32'd0, out32}, 64'hFFFF_FFFF);

    go(64'h8000_0000_0000_0000, ONES, 1'b1, 1'b0, 1'b0); wait_idle();
    chk("ovf_q_out64", out64, 64'h8000_0000_0000_0000); chk("ovf_lat64", lat_obs[0], 64'd1);
    go(64'h8000_0000_0000_0000, ONES, 1'b1, 1'b1, 1'b0); wait_idle();
    chk("ovf_r_out64", out64, 64'd0);
    go(64'h0000_0000_8000_0000, ONES, 1'b1, 1'b0, 1'b0); wait_idle();
    chk("ovf_q_out32", {32'd0, out32}, 64'h8000_0000); chk("ovf_lat32", lat_obs[1], 64'd1);

    go(64'd9, 64'd3, 1'b0, 1'b0, 1'b0); wait_idle();
    chk("small_out64", out64, 64'd3);
`ifdef RV_DIV_SMALLNUM_EN
    chk("small_lat64", lat_obs[0], 64'd1); chk("small_early64", {63'd0, early_obs[0]}, 64'd1);
`else
    chk("small_lat64", lat_obs[0], 64'd65); chk("small_early64", {63'd0, early_obs[0]}, 64'd0);
`endif
    go(64'd9, 64'd3, 1'b0, 1'b0, 1'b1); wait_idle();
    chk("fdd_lat64", lat_obs[0], 64'd65); chk("fdd_early64", {63'd0, early_obs[0]}, 64'd0);
    go(M9, 64'd2, 1'b1, 1'b0, 1'b0); wait_idle();
    chk("sm9_q_out32", {32'd0, out32}, 64'hFFFF_FFFC);

    go(64'hDEAD_BEEF_CAFE_F00D, 64'h12345, 1'b0, 1'b0, 1'b0); wait_idle();
    go(64'hDEAD_BEEF_CAFE_F00D, 64'h12345, 1'b1, 1'b1, 1'b0); wait_idle();
    go(M9, 64'd2, 1'b1, 1'b1, 1'b0); wait_idle();
    chk("sm9_r_out64", out64, ONES);

    // Flush 10 cycles after acceptance of 100/7
    fc0 = fin_cnt[0]; fc1 = fin_cnt[1];
    go(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush_lower = 1'b1;
    @(posedge clk); #1 flush_lower = 1'b0;
    @(negedge clk);
    chk("flush_stall64", {63'd0, st64}, 64'd0);
    wait_idle();
    chk("flush_nofin64", fin_cnt[0] - fc0, 64'd0); chk("flush_nofin32", fin_cnt[1] - fc1, 64'd0);
    chk("flush_out64", out64, ONES);
    go(64'd100, 64'd7, 1'b0, 1'b0, 1'b0); wait_idle();
    chk("after_flush_out64", out64, 64'd14); chk("after_flush_out32", {32'd0, out32}, 64'd14);

    // Reset in the middle of a divide
    fc0 = fin_cnt[0]; fc1 = fin_cnt[1];
    go(64'd100, 64'd7, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    repeat (80) @(posedge clk);
    chk("rst_nofin64", fin_cnt[0] - fc0, 64'd0); chk("rst_nofin32", fin_cnt[1] - fc1, 64'd0);
    chk("rst_out64", out64, 64'd0);

    // Back-to-back: dp_valid held high
    fc0 = fin_cnt[0];
    @(posedge clk); #1;
    op_a = 64'd5; op_b = 64'd0; dp_sign = 1'b0; dp_rem = 1'b1; dp_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 dp_valid = 1'b0;
    wait_idle();
    chk("b2b_short_fins64", fin_cnt[0] - fc0, 64'd5);
    @(posedge clk); #1;
    op_a = 64'd100; op_b = 64'd7; dp_rem = 1'b0; dp_valid = 1'b1;
    repeat (80) @(posedge clk);
    #1 dp_valid = 1'b0;
    wait_idle();
    chk("b2b_out32", {32'd0, out32}, 64'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
